ahb_lite_arbiter: RTL and testbench
===================================

AHB_LITE_ARBITER -- requirements
Module: ahb_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 64: data width of all ports.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have, for X in {imem, dmem}, port io_X_htrans, input, 2: master transfer type; NONSEQ/SEQ = request, IDLE/BUSY = none.
REQ-006 SHALL have io_X_haddr (input, ADDR_W), io_X_hwrite (input, 1), io_X_hsize (input, 3) and io_X_hprot (input, 4): master address-phase controls.
REQ-007 SHALL have io_X_hburst (input, 3) and io_X_hmastlock (input, 1): accepted and ignored.
REQ-008 SHALL have io_X_hwdata, input, DATA_W: master write data, valid in the master's data phase.
REQ-009 SHALL have io_X_hrdata (output, DATA_W), io_X_hready (output, 1) and io_X_hresp (output, 1): master response.
REQ-010 SHALL have io_mem_htrans (output, 2), io_mem_haddr (output, ADDR_W), io_mem_hwrite (output, 1), io_mem_hsize (output, 3), io_mem_hprot (output, 4), io_mem_hburst (output, 3) and io_mem_hmastlock (output, 1): slave address phase.
REQ-011 SHALL have io_mem_hwdata (output, DATA_W), io_mem_hrdata (input, DATA_W), io_mem_hready (input, 1) and io_mem_hresp (input, 1): slave data phase.

Function
REQ-012 SHALL merge the two AHB-Lite masters onto one AHB-Lite slave port; each master sees a private single-master bus.
REQ-013 SHALL keep one pending register per master (valid flag, haddr, hwrite, hsize, hprot).
REQ-014 SHALL set pend_X at a clock edge iff io_X_hready=1 and io_X_htrans[1]=1, capturing that cycle's address-phase controls.
REQ-015 SHALL keep an owner register in {NONE, IMEM, DMEM} naming the master whose transfer is in the slave data phase, and a 1-bit last-grant pointer.
REQ-016 SHALL compute grant combinationally when io_mem_hready=1: if only one pend is set, grant that master; if both are set, grant the master not named by last-grant; if none is set, no grant.
REQ-017 SHALL drive, on grant, io_mem_htrans=NONSEQ (2'b10), io_mem_hburst=SINGLE (3'b000), io_mem_hmastlock=0, and haddr/hwrite/hsize/hprot from the granted pending register.
REQ-018 SHALL otherwise drive io_mem_htrans=IDLE (2'b00), with all other address-phase outputs 0.
REQ-019 SHALL, at each edge with io_mem_hready=1: set owner to the granted master, or NONE if there is no grant; clear that master's pend; update last-grant on grant.
REQ-020 SHALL hold owner, pend and last-grant unchanged at edges with io_mem_hready=0.
REQ-021 SHALL drive io_X_hready = (owner==X and io_mem_hready) or (owner!=X and not pend_X); combinational.
REQ-022 SHALL drive io_X_hrdata=io_mem_hrdata and io_X_hresp=io_mem_hresp when owner==X, else 0 and 0.
REQ-023 SHALL drive io_mem_hwdata from the owner's io_X_hwdata, or 0 when owner=NONE.
REQ-024 SHALL give a zero-wait slave this latency: master address at cycle N, slave address at N+1, master data phase completes at N+2 (exactly one wait state).
REQ-025 SHALL latch a new pipelined request presented on the completion cycle of the previous one with no bubble on the master side.
REQ-026 SHALL, on a two-cycle slave ERROR response, forward both cycles unchanged to the owner; if the master drives IDLE in the second cycle, nothing is latched.
REQ-027 SHALL, while the slave inserts waits, block a newly arriving request from the other master until io_mem_hready=1.

Reset
REQ-028 SHALL, while reset=1 at an edge, clear both pend flags, set owner=NONE and last-grant=DMEM, so IMEM wins the first tie.
REQ-029 SHALL, during and right after reset, output io_mem_htrans=IDLE, io_X_hready=1, io_X_hresp=0, io_X_hrdata=0 and io_mem_hwdata=0.
REQ-030 SHALL abandon any in-flight or pending transfer on reset mid-operation; no completion is reported to either master.

Verification
REQ-031 Single imem read of 0x100 on a zero-wait slave -> io_mem_htrans=NONSEQ/haddr=0x100 one cycle later; io_imem_hready low one cycle, then high with hrdata equal to the slave data.
REQ-032 imem and dmem request in the same cycle after reset -> imem is granted first, dmem on the next slave address phase; each master gets its own data; dmem sees 2 wait states.
REQ-033 Both masters issue back-to-back requests for 8 transfers -> grants strictly alternate, with no starvation and no dropped or duplicated transfer.
REQ-034 dmem write of 0x11223344 to 0x1000_0000 with the slave holding hready low for 3 cycles -> io_mem_hwdata stable at 0x11223344 and io_dmem_hready low throughout; completes on the 4th cycle.
REQ-035 Slave ERROR on a dmem read -> io_dmem_hresp=1 for 2 cycles (hready 0 then 1); imem traffic is unaffected.
REQ-036 reset=1 asserted while the slave data phase is stalled -> next cycle owner=NONE, io_mem_htrans=IDLE, both io_X_hready=1.

Source files
------------

// File: rtl/ahb_lite_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter. Each master gets a one-deep
// pending register; grants alternate on ties and the owner register tracks
// whose transfer currently occupies the slave data phase.
module ahb_lite_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  // imem master
  input  logic [1:0]        io_imem_htrans,
  input  logic [ADDR_W-1:0] io_imem_haddr,
  input  logic              io_imem_hwrite,
  input  logic [2:0]        io_imem_hsize,
  input  logic [3:0]        io_imem_hprot,
  input  logic [2:0]        io_imem_hburst,
  input  logic              io_imem_hmastlock,
  input  logic [DATA_W-1:0] io_imem_hwdata,
  output logic [DATA_W-1:0] io_imem_hrdata,
  output logic              io_imem_hready,
  output logic              io_imem_hresp,
  // dmem master
  input  logic [1:0]        io_dmem_htrans,
  input  logic [ADDR_W-1:0] io_dmem_haddr,
  input  logic              io_dmem_hwrite,
  input  logic [2:0]        io_dmem_hsize,
  input  logic [3:0]        io_dmem_hprot,
  input  logic [2:0]        io_dmem_hburst,
  input  logic              io_dmem_hmastlock,
  input  logic [DATA_W-1:0] io_dmem_hwdata,
  output logic [DATA_W-1:0] io_dmem_hrdata,
  output logic              io_dmem_hready,
  output logic              io_dmem_hresp,
  // slave
  output logic [1:0]        io_mem_htrans,
  output logic [ADDR_W-1:0] io_mem_haddr,
  output logic              io_mem_hwrite,
  output logic [2:0]        io_mem_hsize,
  output logic [3:0]        io_mem_hprot,
  output logic [2:0]        io_mem_hburst,
  output logic              io_mem_hmastlock,
  output logic [DATA_W-1:0] io_mem_hwdata,
  input  logic [DATA_W-1:0] io_mem_hrdata,
  input  logic              io_mem_hready,
  input  logic              io_mem_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {OWN_NONE, OWN_IMEM, OWN_DMEM} owner_e;
  typedef enum logic {LG_IMEM, LG_DMEM} last_e;

  owner_e owner_q, owner_d, owner_cur, grant;
  last_e  last_q, last_d;

  logic pend_imem_q, pend_imem_d, pend_dmem_q, pend_dmem_d;
  logic pend_imem, pend_dmem;
  logic cap_imem, cap_dmem;

  logic [ADDR_W-1:0] paddr_imem_q, paddr_dmem_q;
  logic              pwrite_imem_q, pwrite_dmem_q;
  logic [2:0]        psize_imem_q, psize_dmem_q;
  logic [3:0]        pprot_imem_q, pprot_dmem_q;

  logic unused_inputs;
  assign unused_inputs = ^{io_imem_htrans[0], io_imem_hburst, io_imem_hmastlock,
                           io_dmem_htrans[0], io_dmem_hburst, io_dmem_hmastlock};

  // Reset masks the state so every output is idle during the reset cycle itself,
  // not only after the edge that clears the registers.
  always_comb begin
    owner_cur = reset ? OWN_NONE : owner_q;
    pend_imem = pend_imem_q & ~reset;
    pend_dmem = pend_dmem_q & ~reset;
  end

  // Grant selection: single requester wins, ties go to the master not served last.
  always_comb begin
    grant = OWN_NONE;
    if (io_mem_hready) begin
      if (pend_imem && pend_dmem) begin
        grant = (last_q == LG_DMEM) ? OWN_IMEM : OWN_DMEM;
      end else if (pend_imem) begin
        grant = OWN_IMEM;
      end else if (pend_dmem) begin
        grant = OWN_DMEM;
      end
    end
  end

  // Owner, last-grant and pending flags register.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= LG_DMEM;
      pend_imem_q <= 1'b0;
      pend_dmem_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      pend_imem_q <= pend_imem_d;
      pend_dmem_q <= pend_dmem_d;
    end
  end

  // Next state: grant moves a pending request into the data phase; a master
  // whose address phase completes is captured even while the slave stalls.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    pend_imem_d = pend_imem_q;
    pend_dmem_d = pend_dmem_q;
    cap_imem    = io_imem_hready & io_imem_htrans[1];
    cap_dmem    = io_dmem_hready & io_dmem_htrans[1];
    if (io_mem_hready) begin
      owner_d = grant;
      if (grant == OWN_IMEM) begin
        pend_imem_d = 1'b0;
        last_d      = LG_IMEM;
      end else if (grant == OWN_DMEM) begin
        pend_dmem_d = 1'b0;
        last_d      = LG_DMEM;
      end
    end
    if (cap_imem) pend_imem_d = 1'b1;
    if (cap_dmem) pend_dmem_d = 1'b1;
  end

  // Pending address-phase controls, loaded whenever a master's request is accepted.
  always_ff @(posedge clock) begin
    if (cap_imem) begin
      paddr_imem_q  <= io_imem_haddr;
      pwrite_imem_q <= io_imem_hwrite;
      psize_imem_q  <= io_imem_hsize;
      pprot_imem_q  <= io_imem_hprot;
    end
    if (cap_dmem) begin
      paddr_dmem_q  <= io_dmem_haddr;
      pwrite_dmem_q <= io_dmem_hwrite;
      psize_dmem_q  <= io_dmem_hsize;
      pprot_dmem_q  <= io_dmem_hprot;
    end
  end

  // Outputs: slave address phase from the grant, master responses from the owner.
  always_comb begin
    io_mem_htrans    = HTRANS_IDLE;
    io_mem_haddr     = '0;
    io_mem_hwrite    = 1'b0;
    io_mem_hsize     = '0;
    io_mem_hprot     = '0;
    io_mem_hburst    = '0;
    io_mem_hmastlock = 1'b0;
    case (grant)
      OWN_IMEM: begin
        io_mem_htrans = HTRANS_NONSEQ;
        io_mem_haddr  = paddr_imem_q;
        io_mem_hwrite = pwrite_imem_q;
        io_mem_hsize  = psize_imem_q;
        io_mem_hprot  = pprot_imem_q;
      end
      OWN_DMEM: begin
        io_mem_htrans = HTRANS_NONSEQ;
        io_mem_haddr  = paddr_dmem_q;
        io_mem_hwrite = pwrite_dmem_q;
        io_mem_hsize  = psize_dmem_q;
        io_mem_hprot  = pprot_dmem_q;
      end
      default: ;
    endcase

    io_imem_hready = (owner_cur == OWN_IMEM) ? io_mem_hready : ~pend_imem;
    io_dmem_hready = (owner_cur == OWN_DMEM) ? io_mem_hready : ~pend_dmem;
    io_imem_hrdata = (owner_cur == OWN_IMEM) ? io_mem_hrdata : '0;
    io_dmem_hrdata = (owner_cur == OWN_DMEM) ? io_mem_hrdata : '0;
    io_imem_hresp  = (owner_cur == OWN_IMEM) & io_mem_hresp;
    io_dmem_hresp  = (owner_cur == OWN_DMEM) & io_mem_hresp;

    case (owner_cur)
      OWN_IMEM: io_mem_hwdata = io_imem_hwdata;
      OWN_DMEM: io_mem_hwdata = io_dmem_hwdata;
      default:  io_mem_hwdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed bench for ahb_lite_arbiter: a cycle table plus sequences for
// alternating traffic and a two-cycle error response.
`timescale 1ns/1ps
module tb_ahb_lite_arbiter;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam logic [1:0]  NS = 2'b10;
  localparam logic [1:0]  ID = 2'b00;
  localparam logic [63:0] IWD = 64'hA5A5_0000_0000_A5A5;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    io_imem_htrans, io_dmem_htrans;
  logic [AW-1:0] io_imem_haddr, io_dmem_haddr;
  logic          io_imem_hwrite, io_dmem_hwrite;
  logic [2:0]    io_imem_hsize, io_dmem_hsize;
  logic [3:0]    io_imem_hprot, io_dmem_hprot;
  logic [2:0]    io_imem_hburst, io_dmem_hburst;
  logic          io_imem_hmastlock, io_dmem_hmastlock;
  logic [DW-1:0] io_imem_hwdata, io_dmem_hwdata;
  logic [DW-1:0] io_imem_hrdata, io_dmem_hrdata;
  logic          io_imem_hready, io_dmem_hready;
  logic          io_imem_hresp, io_dmem_hresp;
  logic [1:0]    io_mem_htrans;
  logic [AW-1:0] io_mem_haddr;
  logic          io_mem_hwrite;
  logic [2:0]    io_mem_hsize;
  logic [3:0]    io_mem_hprot;
  logic [2:0]    io_mem_hburst;
  logic          io_mem_hmastlock;
  logic [DW-1:0] io_mem_hwdata;
  logic [DW-1:0] io_mem_hrdata;
  logic          io_mem_hready;
  logic          io_mem_hresp;

  ahb_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .io_imem_htrans(io_imem_htrans), .io_imem_haddr(io_imem_haddr),
    .io_imem_hwrite(io_imem_hwrite), .io_imem_hsize(io_imem_hsize),
    .io_imem_hprot(io_imem_hprot), .io_imem_hburst(io_imem_hburst),
    .io_imem_hmastlock(io_imem_hmastlock), .io_imem_hwdata(io_imem_hwdata),
    .io_imem_hrdata(io_imem_hrdata), .io_imem_hready(io_imem_hready),
    .io_imem_hresp(io_imem_hresp),
    .io_dmem_htrans(io_dmem_htrans), .io_dmem_haddr(io_dmem_haddr),
    .io_dmem_hwrite(io_dmem_hwrite), .io_dmem_hsize(io_dmem_hsize),
    .io_dmem_hprot(io_dmem_hprot), .io_dmem_hburst(io_dmem_hburst),
    .io_dmem_hmastlock(io_dmem_hmastlock), .io_dmem_hwdata(io_dmem_hwdata),
    .io_dmem_hrdata(io_dmem_hrdata), .io_dmem_hready(io_dmem_hready),
    .io_dmem_hresp(io_dmem_hresp),
    .io_mem_htrans(io_mem_htrans), .io_mem_haddr(io_mem_haddr),
    .io_mem_hwrite(io_mem_hwrite), .io_mem_hsize(io_mem_hsize),
    .io_mem_hprot(io_mem_hprot), .io_mem_hburst(io_mem_hburst),
    .io_mem_hmastlock(io_mem_hmastlock), .io_mem_hwdata(io_mem_hwdata),
    .io_mem_hrdata(io_mem_hrdata), .io_mem_hready(io_mem_hready),
    .io_mem_hresp(io_mem_hresp)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst;
    logic [1:0] i_tr;  logic [63:0] i_addr;
    logic [1:0] d_tr;  logic [63:0] d_addr; logic d_wr; logic [63:0] d_wdata;
    logic m_rdy; logic m_resp; logic [63:0] m_rdata;
    logic [1:0] e_tr;  logic [63:0] e_addr; logic e_wr; logic [63:0] e_wdata;
    logic e_irdy; logic e_drdy; logic [63:0] e_irdata; logic [63:0] e_drdata;
    logic e_iresp; logic e_dresp;
  } vec_t;

  function automatic vec_t base();
    vec_t r;
    r.rst = 1'b0; r.i_tr = ID; r.i_addr = '0; r.d_tr = ID; r.d_addr = '0;
    r.d_wr = 1'b0; r.d_wdata = '0; r.m_rdy = 1'b1; r.m_resp = 1'b0; r.m_rdata = '0;
    r.e_tr = ID; r.e_addr = '0; r.e_wr = 1'b0; r.e_wdata = '0;
    r.e_irdy = 1'b1; r.e_drdy = 1'b1; r.e_irdata = '0; r.e_drdata = '0;
    r.e_iresp = 1'b0; r.e_dresp = 1'b0;
    return r;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst;
    io_imem_htrans = v.i_tr; io_imem_haddr = v.i_addr;
    io_dmem_htrans = v.d_tr; io_dmem_haddr = v.d_addr;
    io_dmem_hwrite = v.d_wr; io_dmem_hwdata = v.d_wdata;
    io_mem_hready = v.m_rdy; io_mem_hresp = v.m_resp; io_mem_hrdata = v.m_rdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];
  vec_t r;
  int i_iss, d_iss, i_done, d_done, slv_i, slv_d, last_m, m;
  logic i_out, d_out, nxt_valid;
  logic [63:0] i_oaddr, d_oaddr, nxt_rdata;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io_imem_hwrite = 1'b0; io_imem_hsize = 3'd2; io_imem_hprot = 4'h3;
    io_imem_hburst = 3'd1; io_imem_hmastlock = 1'b0; io_imem_hwdata = IWD;
    io_dmem_hsize = 3'd3; io_dmem_hprot = 4'h1; io_dmem_hburst = 3'd3;
    io_dmem_hmastlock = 1'b1;

    // Reset with a request pending on imem: nothing may leak through.
    r = base(); r.rst = 1; r.i_tr = NS; r.i_addr = 64'h100; r.m_rdata = 64'hDEAD; vecs.push_back(r);
    r = base(); r.m_rdata = 64'hDEAD; vecs.push_back(r);
    // Single imem read of 0x100.
    r = base(); r.i_tr = NS; r.i_addr = 64'h100; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h1111; r.e_tr = NS; r.e_addr = 64'h100; r.e_irdy = 0; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h1111; r.e_irdata = 64'h1111; r.e_wdata = IWD; vecs.push_back(r);
    // Simultaneous requests right after reset: imem first.
    r = base(); r.rst = 1; vecs.push_back(r);
    r = base(); r.i_tr = NS; r.i_addr = 64'h200; r.d_tr = NS; r.d_addr = 64'h300; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h2222; r.e_tr = NS; r.e_addr = 64'h200; r.e_irdy = 0; r.e_drdy = 0; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h2222; r.e_tr = NS; r.e_addr = 64'h300; r.e_irdata = 64'h2222;
    r.e_drdy = 0; r.e_wdata = IWD; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h3333; r.e_drdata = 64'h3333; vecs.push_back(r);
    // dmem write with three slave wait states; imem arrives during the stall.
    r = base(); r.d_tr = NS; r.d_addr = 64'h1000_0000; r.d_wr = 1; vecs.push_back(r);
    r = base(); r.d_wdata = 64'h1122_3344; r.e_tr = NS; r.e_addr = 64'h1000_0000; r.e_wr = 1; r.e_drdy = 0; vecs.push_back(r);
    r = base(); r.m_rdy = 0; r.d_wdata = 64'h1122_3344; r.i_tr = NS; r.i_addr = 64'h400;
    r.e_wdata = 64'h1122_3344; r.e_drdy = 0; vecs.push_back(r);
    for (int k = 0; k < 2; k++) begin
      r = base(); r.m_rdy = 0; r.d_wdata = 64'h1122_3344; r.e_wdata = 64'h1122_3344;
      r.e_drdy = 0; r.e_irdy = 0; vecs.push_back(r);
    end
    r = base(); r.d_wdata = 64'h1122_3344; r.e_tr = NS; r.e_addr = 64'h400; r.e_irdy = 0;
    r.e_wdata = 64'h1122_3344; vecs.push_back(r);
    r = base(); r.m_rdata = 64'h4444; r.e_irdata = 64'h4444; r.e_wdata = IWD; vecs.push_back(r);
    // Reset while the slave data phase is stalled.
    r = base(); r.d_tr = NS; r.d_addr = 64'h500; vecs.push_back(r);
    r = base(); r.e_tr = NS; r.e_addr = 64'h500; r.e_drdy = 0; vecs.push_back(r);
    r = base(); r.m_rdy = 0; r.e_drdy = 0; vecs.push_back(r);
    r = base(); r.rst = 1; r.m_rdy = 0; vecs.push_back(r);
    r = base(); r.m_rdy = 0; vecs.push_back(r);
    r = base(); vecs.push_back(r);

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k]);
      @(negedge clock);
      chk($sformatf("v%0d mem_htrans", k), io_mem_htrans, vecs[k].e_tr);
      chk($sformatf("v%0d mem_haddr", k), io_mem_haddr, vecs[k].e_addr);
      chk($sformatf("v%0d mem_hwrite", k), io_mem_hwrite, vecs[k].e_wr);
      chk($sformatf("v%0d mem_hwdata", k), io_mem_hwdata, vecs[k].e_wdata);
      chk($sformatf("v%0d mem_hburst", k), {io_mem_hburst, io_mem_hmastlock}, 4'h0);
      chk($sformatf("v%0d imem_hready", k), io_imem_hready, vecs[k].e_irdy);
      chk($sformatf("v%0d dmem_hready", k), io_dmem_hready, vecs[k].e_drdy);
      chk($sformatf("v%0d imem_hrdata", k), io_imem_hrdata, vecs[k].e_irdata);
      chk($sformatf("v%0d dmem_hrdata", k), io_dmem_hrdata, vecs[k].e_drdata);
      chk($sformatf("v%0d hresp", k), {io_imem_hresp, io_dmem_hresp}, {vecs[k].e_iresp, vecs[k].e_dresp});
      next_cycle();
    end

    // Both masters stream 8 back-to-back reads; the slave returns ~addr with zero waits.
    i_iss = 0; d_iss = 0; i_done = 0; d_done = 0; slv_i = 0; slv_d = 0; last_m = 0;
    i_out = 0; d_out = 0; nxt_valid = 0; i_oaddr = '0; d_oaddr = '0; nxt_rdata = '0;
    io_mem_hready = 1; io_mem_hresp = 0; io_mem_hrdata = '0;
    io_imem_htrans = NS; io_imem_haddr = 64'h1000;
    io_dmem_htrans = NS; io_dmem_haddr = 64'h2000; io_dmem_hwrite = 0;
    for (int cyc = 0; cyc < 60 && (i_done < 8 || d_done < 8); cyc++) begin
      @(negedge clock);
      nxt_valid = 0;
      if (io_mem_htrans == NS) begin
        m = (io_mem_haddr[13:12] == 2'b01) ? 1 : 2;
        if (last_m == 0) chk("alt_first_grant", m, 1);
        else chk("alt_grant_order", m, 3 - last_m);
        last_m = m;
        if (m == 1) begin chk("alt_imem_slave_addr", io_mem_haddr, 64'h1000 + 8 * slv_i); slv_i++; end
        else begin chk("alt_dmem_slave_addr", io_mem_haddr, 64'h2000 + 8 * slv_d); slv_d++; end
        nxt_valid = 1; nxt_rdata = ~io_mem_haddr;
      end
      if (io_imem_hready) begin
        if (i_out) begin chk("alt_imem_rdata", io_imem_hrdata, ~i_oaddr); i_done++; i_out = 0; end
        if (io_imem_htrans == NS) begin i_out = 1; i_oaddr = io_imem_haddr; i_iss++; end
      end
      if (io_dmem_hready) begin
        if (d_out) begin chk("alt_dmem_rdata", io_dmem_hrdata, ~d_oaddr); d_done++; d_out = 0; end
        if (io_dmem_htrans == NS) begin d_out = 1; d_oaddr = io_dmem_haddr; d_iss++; end
      end
      next_cycle();
      io_mem_hrdata = nxt_valid ? nxt_rdata : '0;
      io_imem_htrans = (i_iss < 8) ? NS : ID; io_imem_haddr = 64'h1000 + 8 * i_iss;
      io_dmem_htrans = (d_iss < 8) ? NS : ID; io_dmem_haddr = 64'h2000 + 8 * d_iss;
    end
    chk("alt_imem_done", i_done, 8);
    chk("alt_dmem_done", d_done, 8);
    chk("alt_slave_count", slv_i + slv_d, 16);

    // dmem read gets a two-cycle ERROR; imem request arrives meanwhile.
    io_dmem_htrans = NS; io_dmem_haddr = 64'h600; io_imem_htrans = ID;
    io_mem_hready = 1; io_mem_hresp = 0; io_mem_hrdata = '0;
    @(negedge clock);
    chk("err0_dmem_hready", io_dmem_hready, 1);
    next_cycle();
    io_dmem_htrans = ID; io_imem_htrans = NS; io_imem_haddr = 64'h700;
    @(negedge clock);
    chk("err1_mem_htrans", io_mem_htrans, NS);
    chk("err1_mem_haddr", io_mem_haddr, 64'h600);
    chk("err1_mem_hsize", io_mem_hsize, 3'd3);
    chk("err1_dmem_hready", io_dmem_hready, 0);
    chk("err1_imem_hready", io_imem_hready, 1);
    next_cycle();
    io_imem_htrans = ID; io_mem_hready = 0; io_mem_hresp = 1;
    @(negedge clock);
    chk("err2_dmem_hresp", io_dmem_hresp, 1);
    chk("err2_dmem_hready", io_dmem_hready, 0);
    chk("err2_imem_hresp", io_imem_hresp, 0);
    chk("err2_imem_hready", io_imem_hready, 0);
    chk("err2_mem_htrans", io_mem_htrans, ID);
    next_cycle();
    io_mem_hready = 1; io_mem_hresp = 1;
    @(negedge clock);
    chk("err3_dmem_hresp", io_dmem_hresp, 1);
    chk("err3_dmem_hready", io_dmem_hready, 1);
    chk("err3_mem_htrans", io_mem_htrans, NS);
    chk("err3_mem_haddr", io_mem_haddr, 64'h700);
    chk("err3_mem_hsize", io_mem_hsize, 3'd2);
    chk("err3_imem_hresp", io_imem_hresp, 0);
    next_cycle();
    io_mem_hresp = 0; io_mem_hrdata = 64'h7777;
    @(negedge clock);
    chk("err4_imem_hready", io_imem_hready, 1);
    chk("err4_imem_hrdata", io_imem_hrdata, 64'h7777);
    chk("err4_imem_hresp", io_imem_hresp, 0);
    chk("err4_dmem_hresp", io_dmem_hresp, 0);
    chk("err4_mem_htrans", io_mem_htrans, ID);
    next_cycle();
    @(negedge clock);
    chk("err5_mem_htrans", io_mem_htrans, ID);
    chk("err5_dmem_hready", io_dmem_hready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
